// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_entry_t : one queued fetch result, {pc, inst}
//   INST_NOP      : instruction presented to decode when nothing is queued
//   PC_STEP       : sequential PC increment in bytes
package fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: ROM, redirect and decode-side signals of the fetch stage.
//   rom_addr / rom_inst                  : combinational ROM read
//   redirect_valid / redirect_pc         : one-cycle redirect from execute
//   if_valid / if_ready / if_inst /
//   if_pc / if_pc_plus4                  : head entry offered to decode
//   fetch_fault                          : sticky misaligned-redirect flag
// Handshake: an entry transfers on a clock edge where if_valid & if_ready are
// both high; if_valid never depends combinationally on if_ready, and while
// if_valid & !if_ready the payload holds unless a redirect or reset occurs.
// master = fetch stage, slave = its environment (ROM, execute, decode).
interface inst_fetch_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_inst;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              if_valid;
   logic              if_ready;
   logic [31:0]       if_inst;
   logic [31:0]       if_pc;
   logic [31:0]       if_pc_plus4;
   logic              fetch_fault;

   modport master (
      output rom_addr, if_valid, if_inst, if_pc, if_pc_plus4, fetch_fault,
      input  rom_inst, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  rom_addr, if_valid, if_inst, if_pc, if_pc_plus4, fetch_fault,
      output rom_inst, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetch_entry_t.
//   push/push_entry : write at tail
//   pop             : drop head (caller only pops when count != 0)
//   flush           : empty the queue; overrides push and pop
//   count           : occupancy 0..2
//   head            : oldest entry (content undefined when count == 0)
// Push and pop together when full is legal: the tail slot equals the head
// slot, and the head is read before the edge that overwrites it.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t mem_q [2];
   fetch_entry_t mem_d [2];
   logic         rd_q, rd_d;
   logic         wr_q, wr_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush) begin
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_q] = push_entry;
            wr_d        = ~wr_q;
         end
         if (pop) begin
            rd_d = ~rd_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage in front of a combinational ROM.
//   clk, reset : core clock, asynchronous active-high reset
//   bus        : inst_fetch_if.master (ROM read, redirect, decode handshake,
//                fetch_fault)
// The PC drives the ROM directly; each push captures {pc, rom_inst} into a
// 2-entry queue whose head is offered to decode. A redirect flushes the queue
// and reloads the PC; a misaligned target latches fetch_fault, which stops
// all further fetching until reset.
module inst_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 12,
   parameter int          QDEPTH   = 2
)(
   input  logic          clk,
   input  logic          reset,
   inst_fetch_if.master  bus
);

   logic [31:0]  pc_q, pc_d;
   logic         fault_q, fault_d;
   logic         push, pop, q_valid;
   logic [1:0]   q_count;
   fetch_entry_t q_head;
   fetch_entry_t new_entry;

   assign q_valid   = (q_count != 2'd0);
   assign pop       = q_valid & bus.if_ready;
   // A full queue can still accept when decode drains the head this cycle.
   assign push      = !fault_q & !bus.redirect_valid &
                      ((q_count < 2'(QDEPTH)) | pop);
   assign new_entry = '{pc: pc_q, inst: bus.rom_inst};

   fetch_queue u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (bus.redirect_valid),
      .push_entry (new_entry),
      .count      (q_count),
      .head       (q_head)
   );

   always_comb begin
      pc_d    = pc_q;
      fault_d = fault_q;
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
         end
      end else if (push) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      bus.if_valid    = q_valid;
      bus.if_inst     = INST_NOP;
      bus.if_pc       = 32'd0;
      bus.if_pc_plus4 = 32'd0;
      if (q_valid) begin
         bus.if_inst     = q_head.inst;
         bus.if_pc       = q_head.pc;
         bus.if_pc_plus4 = q_head.pc + PC_STEP;
      end
   end

   // High PC bits are deliberately dropped: the ROM aliases across them.
   assign bus.rom_addr    = pc_q[ADDR_W-1:0];
   assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] rom_mem [0:1023];
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_fault;

  inst_fetch_if #(.ADDR_W(12)) bus ();

  inst_fetch #(.RESET_PC(RESET_PC_TB), .ADDR_W(12), .QDEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_inst = rom_mem[bus.rom_addr[11:2]];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RESET_PC_TB;
    m_fault = 1'b0;
  endtask

  // Compare every output against the reference, then advance the reference
  // by one clock edge using the inputs currently applied.
  task automatic cycle();
    logic        pop;
    logic        push;
    logic [63:0] hd;
    #1;
    if (exp_q.size() != 0) begin
      hd = exp_q[0];
      check("if_valid", {31'd0, bus.if_valid}, 32'd1);
      check("if_pc", bus.if_pc, hd[63:32]);
      check("if_inst", bus.if_inst, hd[31:0]);
      check("if_pc_plus4", bus.if_pc_plus4, hd[63:32] + 32'd4);
    end else begin
      check("if_valid", {31'd0, bus.if_valid}, 32'd0);
      check("if_pc_empty", bus.if_pc, 32'd0);
      check("if_inst_empty", bus.if_inst, NOP);
      check("if_pc_plus4_empty", bus.if_pc_plus4, 32'd0);
    end
    check("rom_addr", {20'd0, bus.rom_addr}, {20'd0, m_pc[11:0]});
    check("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
    pop  = (exp_q.size() != 0) && bus.if_ready;
    push = !m_fault && !bus.redirect_valid && ((exp_q.size() < 2) || pop);
    if (pop) void'(exp_q.pop_front());
    if (bus.redirect_valid) begin
      exp_q.delete();
      m_pc = bus.redirect_pc;
      if (bus.redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
    end else if (push) begin
      exp_q.push_back({m_pc, rom_mem[m_pc[11:2]]});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    bus.if_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic reset_and_release();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 1024; k++) rom_mem[k] = k;
    drive(1'b1, 1'b0, 32'd0);
    reset = 1'b1;
    model_reset();
    #12;
    // outputs while reset is held
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_if_inst", bus.if_inst, NOP);
    check("rst_if_pc", bus.if_pc, 32'd0);
    check("rst_if_pc_plus4", bus.if_pc_plus4, 32'd0);
    check("rst_rom_addr", {20'd0, bus.rom_addr}, {20'd0, RESET_PC_TB[11:0]});
    check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // streaming with if_ready high
    cycle();
    check("stream_first_pc", bus.if_pc, 32'd0);
    check("stream_first_inst", bus.if_inst, 32'd0);
    cycle();
    check("stream_second_pc", bus.if_pc, 32'd4);
    check("stream_second_inst", bus.if_inst, 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // fill the queue with if_ready low, then drain
    reset_and_release();
    drive(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    check("full_rom_addr", {20'd0, bus.rom_addr}, 32'h008);
    check("full_head_pc", bus.if_pc, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    cycle();
    check("drain_pc1", bus.if_pc, 32'd4);
    cycle();
    check("drain_pc2", bus.if_pc, 32'd8);
    cycle();

    // redirect while full
    drive(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b0, 1'b1, 32'h100);
    cycle();
    drive(1'b0, 1'b0, 32'd0);
    check("redir_valid_low", {31'd0, bus.if_valid}, 32'd0);
    check("redir_rom_addr", {20'd0, bus.rom_addr}, 32'h100);
    cycle();
    check("redir_pc", bus.if_pc, 32'h100);
    check("redir_inst", bus.if_inst, 32'd64);
    check("redir_pc_plus4", bus.if_pc_plus4, 32'h104);
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle();

    // redirect together with a pop
    drive(1'b1, 1'b1, 32'h200);
    cycle();
    drive(1'b1, 1'b0, 32'd0);
    cycle();
    check("redir_pop_pc", bus.if_pc, 32'h200);
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic with aligned redirects and aliased high PC bits
    for (int k = 0; k < 1024; k++) rom_mem[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      cycle();
    end

    // asynchronous reset with a full queue
    reset_and_release();
    drive(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    check("pre_areset_valid", {31'd0, bus.if_valid}, 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("areset_valid", {31'd0, bus.if_valid}, 32'd0);
    check("areset_inst", bus.if_inst, NOP);
    check("areset_rom_addr", {20'd0, bus.rom_addr}, {20'd0, RESET_PC_TB[11:0]});
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle();

    // misaligned redirect
    drive(1'b1, 1'b1, 32'h102);
    cycle();
    drive(1'b1, 1'b0, 32'd0);
    check("fault_set", {31'd0, bus.fetch_fault}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 32'd0);
      cycle();
    end
    check("fault_valid_low", {31'd0, bus.if_valid}, 32'd0);
    drive(1'b1, 1'b1, 32'h300);
    cycle();
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    check("fault_sticky", {31'd0, bus.fetch_fault}, 32'd1);
    check("fault_pc_updated", {20'd0, bus.rom_addr}, 32'h300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
